// File: rtl/bram_dump_reader_pkg.sv
// Shared definitions for the BRAM dump reader: FSM state codes and word width.
package bram_dump_reader_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [2:0] DUMP_IDLE = 3'd0;
  localparam logic [2:0] DUMP_ADDR = 3'd1;
  localparam logic [2:0] DUMP_CAPT = 3'd2;
  localparam logic [2:0] DUMP_SEND = 3'd3;
  localparam logic [2:0] DUMP_DONE = 3'd4;

  function automatic logic dump_active(input logic [2:0] state);
    return state != DUMP_IDLE;
  endfunction

endpackage

// File: rtl/bram_dump_reader.sv
// Debug-port read-back engine: walks a BRAM word range and streams each word,
// tagged with its byte address, over valid/ready while stalling the CPU.
module bram_dump_reader
  import bram_dump_reader_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = DATA_WIDTH,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              abort,
  output logic [ADDR_W-1:0] debug_addr,
  input  logic [DATA_W-1:0] debug_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic              cpu_stall
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [ADDR_W-1:0] debug_addr_q, debug_addr_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic              m_last_q, m_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] base_word_s;
  logic [ADDR_W-1:0] next_addr_s;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

  assign base_word_s = word_align(base_addr);
  assign next_addr_s = cur_addr_q + ADDR_W'(4);

  // Next-state and output-register computation; debug_addr is loaded on entry to ADDR.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    debug_addr_d = debug_addr_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_addr_d     = m_addr_q;
    m_last_d     = m_last_q;
    done_d       = 1'b0;
    if (abort && dump_active(state_q)) begin
      state_d   = DUMP_IDLE;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end else begin
      case (state_q)
        DUMP_IDLE: begin
          if (start) begin
            cur_addr_d  = base_word_s;
            remaining_d = word_count;
            if (word_count != CNT_W'(0)) begin
              debug_addr_d = base_word_s;
              state_d      = DUMP_ADDR;
            end else begin
              state_d = DUMP_DONE;
            end
          end else begin
            state_d = DUMP_IDLE;
          end
        end
        DUMP_ADDR: state_d = DUMP_CAPT;
        DUMP_CAPT: begin
          m_data_d  = debug_data;
          m_addr_d  = cur_addr_q;
          m_valid_d = 1'b1;
          m_last_d  = (remaining_q == CNT_W'(1));
          state_d   = DUMP_SEND;
        end
        DUMP_SEND: begin
          if (m_ready) begin
            m_valid_d   = 1'b0;
            m_last_d    = 1'b0;
            cur_addr_d  = next_addr_s;
            remaining_d = remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
              state_d = DUMP_DONE;
            end else begin
              debug_addr_d = next_addr_s;
              state_d      = DUMP_ADDR;
            end
          end else begin
            state_d = DUMP_SEND;
          end
        end
        DUMP_DONE: begin
          done_d  = 1'b1;
          state_d = DUMP_IDLE;
        end
        default: state_d = DUMP_IDLE;
      endcase
    end
    busy_d = dump_active(state_d);
  end

  // State, counters and registered outputs with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= DUMP_IDLE;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      debug_addr_q <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_addr_q     <= '0;
      m_last_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      debug_addr_q <= debug_addr_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_addr_q     <= m_addr_d;
      m_last_q     <= m_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign debug_addr = debug_addr_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_addr     = m_addr_q;
  assign m_last     = m_last_q;
  assign busy       = busy_q;
  assign cpu_stall  = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_bram_dump_reader.sv
// Bench for bram_dump_reader: a memory array stands in for the BRAM, a queue-based
// model predicts every cycle's outputs, and directed steps pin literal beats.
module tb_bram_dump_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        m_ready = 1'b0;
  logic [11:0] base_addr = 12'd0;
  logic [10:0] word_count = 11'd0;
  logic [11:0] debug_addr;
  logic [31:0] debug_data;
  logic        m_valid, m_last, busy, done, cpu_stall;
  logic [31:0] m_data;
  logic [11:0] m_addr;

  logic [31:0] mem [0:1023];
  assign debug_data = mem[debug_addr[11:2]];

  bram_dump_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .abort(abort), .debug_addr(debug_addr),
    .debug_data(debug_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_addr(m_addr), .m_last(m_last), .busy(busy),
    .done(done), .cpu_stall(cpu_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  beat_t log_q[$];
  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int ready_mode = 0;
  int ready_ctr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected beats queue plus cycle countdowns for valid and done.
  int    done_cd = -1;
  int    valid_cd = 0;
  bit    active = 1'b0;
  bit    prev_hold = 1'b0;
  logic [31:0] prev_data;
  logic [11:0] prev_addr;

  always @(negedge clk) begin
    bit exp_done, exp_valid, idle_now;
    if (!rst) begin
      exp_q.delete();
      done_cd = -1; valid_cd = 0; active = 1'b0; prev_hold = 1'b0;
    end else begin
      if (valid_cd > 0) valid_cd--;
      exp_done = 1'b0;
      if (done_cd > 0) begin
        done_cd--;
        if (done_cd == 0) begin exp_done = 1'b1; done_cd = -1; active = 1'b0; end
      end
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(active));
      chk("cpu_stall", 32'(cpu_stall), 32'(active));
      exp_valid = active && (exp_q.size() > 0) && (valid_cd == 0);
      chk("m_valid", 32'(m_valid), 32'(exp_valid));
      if (exp_valid && m_valid) begin
        chk("m_addr", 32'(m_addr), 32'(exp_q[0].addr));
        chk("m_data", m_data, exp_q[0].data);
        chk("m_last", 32'(m_last), 32'(exp_q.size() == 1));
      end
      if (prev_hold) begin
        chk("hold_addr", 32'(m_addr), 32'(prev_addr));
        chk("hold_data", m_data, prev_data);
      end
      if (done) done_seen++;
      prev_hold = m_valid && !m_ready && !abort;
      prev_addr = m_addr;
      prev_data = m_data;
      idle_now = !active;
      if (abort && active) begin
        exp_q.delete();
        done_cd = -1; valid_cd = 0; active = 1'b0;
      end else if (exp_valid && m_valid && m_ready) begin
        log_q.push_back('{addr: m_addr, data: m_data, last: m_last});
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) done_cd = 2;
        else valid_cd = 3;
      end
      if (start && idle_now) begin
        active = 1'b1;
        for (int i = 0; i < int'(word_count); i++) begin
          int idx;
          idx = (int'(base_addr) / 4 + i) % 1024;
          exp_q.push_back('{addr: 12'(idx * 4), data: mem[idx], last: 1'b0});
        end
        if (word_count == 11'd0) done_cd = 2;
        else valid_cd = 3;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: m_ready = 1'b1;
      1: begin m_ready = (ready_ctr % 3 == 0); ready_ctr++; end
      2: m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  endtask

  task automatic pulse_start(input logic [11:0] b, input logic [10:0] c);
    start = 1'b1; base_addr = b; word_count = c;
    cyc();
    start = 1'b0;
  endtask

  task automatic timeout_fail(input string name);
    checks++; errors++;
    $display("FAIL %s: wait bound expired, got timeout expected event", name);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    cyc();
    while (busy && n < 400) begin cyc(); n++; end
    if (n >= 400) timeout_fail(name);
    cyc();
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!m_valid && n < 50) begin cyc(); n++; end
    if (n >= 50) timeout_fail(name);
  endtask

  task automatic chk_beat(input string name, input int i, input logic [11:0] a,
                          input logic [31:0] d, input logic l);
    if (log_q.size() > i) begin
      chk({name, "_addr"}, 32'(log_q[i].addr), 32'(a));
      chk({name, "_data"}, log_q[i].data, d);
      chk({name, "_last"}, 32'(log_q[i].last), 32'(l));
    end else begin
      chk({name, "_present"}, 32'(log_q.size()), 32'(i + 1));
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h11111111; mem[1] = 32'h22222222; mem[2] = 32'h33333333;
    mem[1023] = 32'hDEADBEEF;
    #2 rst = 1'b0;
    cyc(); cyc();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_m_addr", 32'(m_addr), 32'd0);
    chk("rst_debug_addr", 32'(debug_addr), 32'd0);
    chk("rst_busy_done", 32'({busy, done, cpu_stall, m_last}), 32'd0);
    rst = 1'b1;
    cyc();

    // Basic three-word dump with the consumer always ready.
    ready_mode = 0; log_q.delete(); done_seen = 0;
    pulse_start(12'h000, 11'd3);
    wait_idle("t1_idle");
    chk("t1_beats", 32'(log_q.size()), 32'd3);
    chk_beat("t1_b0", 0, 12'h000, 32'h11111111, 1'b0);
    chk_beat("t1_b1", 1, 12'h004, 32'h22222222, 1'b0);
    chk_beat("t1_b2", 2, 12'h008, 32'h33333333, 1'b1);
    chk("t1_done_count", 32'(done_seen), 32'd1);

    // Same dump with ready 1 high / 2 low.
    ready_mode = 1; ready_ctr = 0; log_q.delete(); done_seen = 0;
    pulse_start(12'h000, 11'd3);
    wait_idle("t2_idle");
    chk("t2_beats", 32'(log_q.size()), 32'd3);
    chk_beat("t2_b0", 0, 12'h000, 32'h11111111, 1'b0);
    chk_beat("t2_b2", 2, 12'h008, 32'h33333333, 1'b1);
    chk("t2_done_count", 32'(done_seen), 32'd1);

    // Address wrap from the top word back to zero.
    ready_mode = 0; log_q.delete(); mem[0] = 32'hCAFEF00D;
    pulse_start(12'hFFC, 11'd2);
    wait_idle("t3_idle");
    chk_beat("t3_b0", 0, 12'hFFC, 32'hDEADBEEF, 1'b0);
    chk_beat("t3_b1", 1, 12'h000, 32'hCAFEF00D, 1'b1);
    mem[0] = 32'h11111111;

    // Zero-length dump: one busy cycle, done two cycles after start.
    log_q.delete(); done_seen = 0;
    pulse_start(12'h010, 11'd0);
    chk("t4_busy_c1", 32'({busy, done}), 32'b10);
    cyc();
    chk("t4_busy_c2", 32'({busy, done}), 32'b01);
    cyc();
    chk("t4_done_c3", 32'(done), 32'd0);
    chk("t4_no_beats", 32'(log_q.size()), 32'd0);

    // Abort during the second SEND, then a fresh single-word dump.
    log_q.delete(); done_seen = 0;
    pulse_start(12'h000, 11'd5);
    begin
      int n = 0;
      while (log_q.size() < 1 && n < 50) begin cyc(); n++; end
      if (n >= 50) timeout_fail("t5_first_beat");
    end
    ready_mode = 3; m_ready = 1'b0;
    wait_valid("t5_second_send");
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t5_abort_valid", 32'(m_valid), 32'd0);
    chk("t5_abort_busy", 32'(busy), 32'd0);
    cyc(); cyc();
    chk("t5_no_done", 32'(done_seen), 32'd0);
    chk("t5_one_beat", 32'(log_q.size()), 32'd1);
    ready_mode = 0; log_q.delete();
    pulse_start(12'h004, 11'd1);
    wait_idle("t5b_idle");
    chk("t5b_beats", 32'(log_q.size()), 32'd1);
    chk_beat("t5b_b0", 0, 12'h004, 32'h22222222, 1'b1);

    // Misaligned base, start while busy, then async reset mid-SEND.
    ready_mode = 3;
    pulse_start(12'h006, 11'd2);
    wait_valid("t6_valid");
    chk("t6_aligned_addr", 32'(m_addr), 32'h004);
    start = 1'b1; base_addr = 12'h100; word_count = 11'd4;
    cyc();
    start = 1'b0;
    chk("t6_ignored_addr", 32'(m_addr), 32'h004);
    chk("t6_ignored_data", m_data, 32'h22222222);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_outs", 32'({m_valid, m_last, busy, done, cpu_stall}), 32'd0);
    chk("t6_rst_data", m_data, 32'd0);
    chk("t6_rst_addr", 32'({m_addr, debug_addr}), 32'd0);
    cyc();
    rst = 1'b1;
    cyc();

    // Randomized traffic: random ranges, ready, stray starts and aborts.
    ready_mode = 2;
    for (int k = 0; k < 3000; k++) begin
      start = ($urandom_range(0, 7) == 0);
      base_addr = ($urandom_range(0, 3) == 0) ? 12'(12'hFF0 + $urandom_range(0, 15))
                                              : 12'($urandom);
      word_count = 11'($urandom_range(0, 6));
      abort = ($urandom_range(0, 59) == 0);
      cyc();
    end
    start = 1'b0; abort = 1'b0; ready_mode = 0;
    wait_idle("rand_idle");
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
